// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths and saturation limits for the FIR tap multiplier
package fir_pkg;

  function automatic int prod_w(input int a_w, input int b_w);
    return a_w + b_w;
  endfunction

  function automatic longint sat_max(input int out_w);
    return (longint'(1) <<< (out_w - 1)) - 1;
  endfunction

  function automatic longint sat_min(input int out_w);
    return -(longint'(1) <<< (out_w - 1));
  endfunction

endpackage

// File: rtl/fir_pipe_mult_if.sv
// rtl/fir_pipe_mult_if.sv - sample/coefficient in, rounded product out, valid/ready both sides
interface fir_pipe_mult_if #(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] res;
  logic             ovf;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, res, ovf
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, res, ovf
  );
endinterface

// File: rtl/fir_round_sat.sv
// rtl/fir_round_sat.sv - round-half-up shift and narrow of the full product
// Saturates out-of-range results when FIR_MULT_SAT_EN is defined, wraps otherwise.
module fir_round_sat
  import fir_pkg::*;
#(
  parameter int A_W   = 16,
  parameter int B_W   = 16,
  parameter int OUT_W = 16,
  parameter int SHIFT = 15
) (
  input  logic signed [prod_w(A_W, B_W)-1:0] p,
  output logic signed [OUT_W-1:0]            res,
  output logic                               ovf
);
  localparam int RW = prod_w(A_W, B_W) + 1;
  localparam logic signed [RW-1:0] MAXV = RW'(sat_max(OUT_W));
  localparam logic signed [RW-1:0] MINV = RW'(sat_min(OUT_W));

  // One guard bit keeps (-2^(A_W-1))*(-2^(B_W-1)) + half from overflowing the adder
  logic signed [RW-1:0] pe;
  logic signed [RW-1:0] r;

  assign pe = {p[RW-2], p};

  generate
    if (SHIFT > 0) begin : g_rnd
      localparam logic signed [RW-1:0] HALF = RW'(1) << (SHIFT - 1);
      assign r = (pe + HALF) >>> SHIFT;
    end else begin : g_nornd
      assign r = pe;
    end
  endgenerate

  assign ovf = (r > MAXV) || (r < MINV);

`ifdef FIR_MULT_SAT_EN
  assign res = ovf ? (r[RW-1] ? MINV[OUT_W-1:0] : MAXV[OUT_W-1:0]) : r[OUT_W-1:0];
`else
  assign res = r[OUT_W-1:0];
`endif

endmodule

// File: rtl/fir_pipe_mult.sv
// rtl/fir_pipe_mult.sv - pipelined signed tap multiplier with global-stall backpressure
// Narrowing behaviour selected by FIR_MULT_SAT_EN (see fir_round_sat).
module fir_pipe_mult
  import fir_pkg::*;
#(
  parameter int A_W    = 16,
  parameter int B_W    = 16,
  parameter int OUT_W  = 16,
  parameter int SHIFT  = 15,
  parameter int STAGES = 3
) (
  input logic            clk,
  input logic            rst_n,
  fir_pipe_mult_if.slave bus
);
  localparam int PW = prod_w(A_W, B_W);

  logic                    en;
  logic [STAGES-1:0]       vld;
  logic signed [PW-1:0]    prod;
  logic signed [PW-1:0]    p_last;
  logic signed [OUT_W-1:0] rs_res;
  logic                    rs_ovf;
  logic signed [OUT_W-1:0] res_q;
  logic                    ovf_q;

  // Whole pipeline freezes while a result is waiting on the accumulator
  assign en            = !(vld[STAGES-1] && !bus.out_ready);
  assign bus.in_ready  = en;
  assign bus.out_valid = vld[STAGES-1];
  assign bus.res       = res_q;
  assign bus.ovf       = ovf_q;

  assign prod = $signed({{B_W{bus.a[A_W-1]}}, bus.a}) * $signed({{A_W{bus.b[B_W-1]}}, bus.b});

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (en) begin
      vld[0] <= bus.in_valid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
    end
  end

  generate
    if (STAGES == 1) begin : g_flat
      assign p_last = prod;
    end else begin : g_pipe
      logic signed [PW-1:0] p_q [STAGES-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES - 1; i++) p_q[i] <= '0;
        end else if (en) begin
          p_q[0] <= prod;
          for (int i = 1; i < STAGES - 1; i++) p_q[i] <= p_q[i-1];
        end
      end

      assign p_last = p_q[STAGES-2];
    end
  endgenerate

  fir_round_sat #(
    .A_W  (A_W),
    .B_W  (B_W),
    .OUT_W(OUT_W),
    .SHIFT(SHIFT)
  ) u_round_sat (
    .p  (p_last),
    .res(rs_res),
    .ovf(rs_ovf)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      res_q <= '0;
      ovf_q <= 1'b0;
    end else if (en) begin
      res_q <= rs_res;
      ovf_q <= rs_ovf;
    end
  end

endmodule

// File: tb/tb_fir_pipe_mult.sv
// tb/tb_fir_pipe_mult.sv - directed checks of fir_pipe_mult at default parameters
module tb_fir_pipe_mult;
  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fir_pipe_mult_if #(.A_W(16), .B_W(16), .OUT_W(16)) bus ();

  fir_pipe_mult #(
    .A_W(16), .B_W(16), .OUT_W(16), .SHIFT(15), .STAGES(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    bus.in_valid = 1'b0;
    bus.a        = '0;
    bus.b        = '0;
  endtask

  logic [15:0] bp_a   [5] = '{16'h0010, 16'h0011, 16'h7FFF, 16'h8000, 16'hFFFD};
  logic [15:0] bp_exp [5] = '{16'h0008, 16'h0009, 16'h4000, 16'hC000, 16'hFFFF};
  logic        iv_seq [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  logic        ov_exp [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  initial begin
    int          ni;
    int          no;
    int          stall_left;
    bit          stalled;
    logic [15:0] held;
    logic [15:0] ovf_res_exp;

    rst_n = 1'b0;
    idle();
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_res", bus.res, 0);
    check("rst_ovf", bus.ovf, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;

    // Basic: exact 3-edge latency
    bus.in_valid = 1'b1; bus.a = 16'h4000; bus.b = 16'h4000;
    tick();
    idle();
    check("basic_lat1", bus.out_valid, 0);
    tick();
    check("basic_lat2", bus.out_valid, 0);
    tick();
    check("basic_valid", bus.out_valid, 1);
    check("basic_res", bus.res, 32'h2000);
    check("basic_ovf", bus.ovf, 0);
    tick();
    check("basic_drain", bus.out_valid, 0);

    // Rounding half-up, back to back
    bus.in_valid = 1'b1; bus.a = 16'h0001; bus.b = 16'h4000;
    tick();
    bus.a = 16'hFFFF;
    tick();
    idle();
    tick();
    check("rnd_pos_valid", bus.out_valid, 1);
    check("rnd_pos_res", bus.res, 32'h0001);
    tick();
    check("rnd_neg_valid", bus.out_valid, 1);
    check("rnd_neg_res", bus.res, 32'h0000);
    tick();

    // Most-negative squared
`ifdef FIR_MULT_SAT_EN
    ovf_res_exp = 16'h7FFF;
`else
    ovf_res_exp = 16'h8000;
`endif
    bus.in_valid = 1'b1; bus.a = 16'h8000; bus.b = 16'h8000;
    tick();
    idle();
    tick();
    tick();
    check("ovf_valid", bus.out_valid, 1);
    check("ovf_res", bus.res, {16'h0, ovf_res_exp});
    check("ovf_flag", bus.ovf, 1);
    tick();

    // Backpressure: 5 back-to-back samples, 2-cycle stall on the first result
    ni = 0; no = 0; stall_left = 2; stalled = 0; held = '0;
    bus.b = 16'h4000;
    for (int cyc = 0; cyc < 40 && no < 5; cyc++) begin
      bus.in_valid  = (ni < 5);
      bus.a         = bp_a[(ni < 5) ? ni : 0];
      bus.out_ready = !(bus.out_valid && stall_left > 0);
      #1;
      if (bus.out_valid && !bus.out_ready) begin
        check("bp_in_ready_stall", bus.in_ready, 0);
        if (stalled) check("bp_res_held", bus.res, {16'h0, held});
        held = bus.res;
        stalled = 1;
        stall_left--;
      end
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("bp_res%0d", no), bus.res, {16'h0, bp_exp[no]});
        check($sformatf("bp_ovf%0d", no), bus.ovf, 0);
        no++;
      end
      if (bus.in_valid && bus.in_ready) ni++;
      tick();
    end
    check("bp_count", no, 5);
    check("bp_stall_seen", stall_left, 0);
    idle();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("bp_no_dup", bus.out_valid, 0);
      tick();
    end

    // Bubbles are preserved, not compressed
    bus.a = 16'h0002; bus.b = 16'h4000;
    for (int k = 0; k < 6; k++) begin
      bus.in_valid = iv_seq[k];
      tick();
      check($sformatf("bub_valid%0d", k), bus.out_valid, ov_exp[k]);
      if (ov_exp[k]) check($sformatf("bub_res%0d", k), bus.res, 32'h0001);
    end
    idle();

    // Reset while stalled with 3 samples in flight
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.a = 16'h7FFF; bus.b = 16'h7FFF;
    tick();
    tick();
    tick();
    idle();
    #1;
    check("mrst_pre_valid", bus.out_valid, 1);
    check("mrst_pre_res", bus.res, 32'h7FFE);
    check("mrst_pre_in_ready", bus.in_ready, 0);
    rst_n = 1'b0;
    tick();
    check("mrst_valid", bus.out_valid, 0);
    check("mrst_res", bus.res, 0);
    check("mrst_ovf", bus.ovf, 0);
    check("mrst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("mrst_no_stale", bus.out_valid, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fir_pipe_mult.md
# fir_pipe_mult

Pipelined, parametrised signed multiplier for the FIR filter datapath, replacing the purely combinational tap multiplier. It multiplies a sample by a coefficient, applies a fixed-point right shift with round-half-up, and narrows to a configurable output width. It sits between the tap delay line and the accumulator. A valid/ready handshake with full-pipeline backpressure lets the accumulator stall the tap path.

## Interface
- A_W, 16, sample operand width (signed, ≥2)
- B_W, 16, coefficient operand width (signed, ≥2)
- OUT_W, 16, result width (signed, 2..A_W+B_W)
- SHIFT, 15, fractional bits dropped from the full product (0..A_W+B_W-2)
- STAGES, 3, pipeline register stages, equal to the latency (≥1)

- clk  in  1  single clock, rising edge
- rst_n  in  1  synchronous reset, active-low
- in_valid  in  1  a/b valid
- in_ready  out  1  block accepts a/b this cycle
- a  in  A_W  signed sample
- b  in  B_W  signed coefficient
- out_valid  out  1  res valid
- out_ready  in  1  downstream accepts res
- res  out  OUT_W  signed rounded/narrowed product
- ovf  out  1  res was clipped or wrapped; qualified by out_valid

## Operation
- Full product: P = a*b, signed, A_W+B_W bits, exact.
- Rounding (SHIFT>0): R = (P + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, computed at A_W+B_W+1 bits. SHIFT=0 gives R = P.
- Narrowing of R to OUT_W follows the Configuration section. ovf=1 iff R lies outside [-2^(OUT_W-1), 2^(OUT_W-1)-1].
- Pipeline: stage 1 registers P and a valid bit. Round/narrow logic feeds the last stage. With STAGES=1 all logic sits before the single register.
- Global stall: en = !(out_valid && !out_ready). Every stage, including its valid bit, advances only when en=1.
- in_ready = en. A transfer occurs on in_valid && in_ready. A stage loaded without a transfer receives valid=0, creating a bubble.
- Bubbles are not compressed. A stall freezes all stages.
- There is no internal state beyond the pipeline registers, and no FSM.

## Timing
- Latency is exactly STAGES cycles from an input transfer to out_valid, provided no stall occurs.
- Throughput is 1 sample/cycle while out_ready=1.
- in_ready is combinational from out_ready and out_valid. There is no combinational path from a/b to any output.
- While out_valid=1 and out_ready=0, res and ovf are held stable and in_ready=0.
- Reset (rst_n=0 at a clk edge):
  - all valid bits clear
  - res=0, ovf=0
  - in_ready=1 in the following cycle
  - in-flight samples are discarded
- Reset asserted during a stall also clears the stall.
- A simultaneous out transfer and in transfer in the same cycle is legal. The pipeline shifts by one.
- Boundary case: a = -2^(A_W-1) and b = -2^(B_W-1) gives the maximum positive P. This must not overflow the internal A_W+B_W+1-bit rounding adder.

## Configuration
- FIR_MULT_SAT_EN defined: an out-of-range R saturates to 2^(OUT_W-1)-1 or -2^(OUT_W-1) according to sign, and ovf=1.
- FIR_MULT_SAT_EN undefined: res = R[OUT_W-1:0] (two's-complement wrap). ovf still flags out-of-range.

## Structure
- The shared package fir_pkg holds:
  - a function returning the full product width (A_W+B_W)
  - the saturation limit constants as functions of OUT_W
- The sub-module fir_round_sat is combinational. It takes P and produces res and ovf, parametrised by widths and SHIFT, and contains the FIR_MULT_SAT_EN branch.
- The top level holds the pipeline registers, the valid chain, and the stall logic.

## Test plan
All cases use the defaults (A_W=B_W=OUT_W=16, SHIFT=15, STAGES=3).
- Basic: a=0x4000, b=0x4000, out_ready=1 → res=0x2000, ovf=0, out_valid exactly 3 cycles after the transfer.
- Rounding: a=1, b=0x4000 → res=0x0001. a=-1, b=0x4000 → res=0x0000.
- Overflow: a=0x8000, b=0x8000 → with FIR_MULT_SAT_EN, res=0x7FFF, ovf=1. Without the macro, res=0x8000, ovf=1.
- Backpressure:
  - Drive 5 back-to-back samples and hold out_ready=0 for 2 cycles once the first result is valid.
  - Required: res held stable, in_ready=0 during the stall.
  - All 5 results emerge in order with no loss or duplication.
- Bubbles: in_valid is toggled 1,0,1 → out_valid follows 1,0,1 with 3-cycle latency.
- Reset mid-stream:
  - Pull rst_n low for 1 cycle with 3 samples in flight.
  - Required: next cycle out_valid=0, res=0, ovf=0, in_ready=1.
  - No stale result appears afterwards.
